// File: rtl/l2_req_queue.sv
// Miss-request queue between the I-cache and the L2 model: FWFT circular buffer
// with tail coalescing and saturating enqueue/coalesce/drop statistics.
module l2_req_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 n,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       l2_valid,
  output logic [ADDR_W-1:0]          l2_addr,
  input  logic                       l2_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           enq_cnt,
  output logic [CNT_W-1:0]           coal_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_Q = PTR_W + 1;
  localparam logic [CNT_Q-1:0] DEPTH_Q = CNT_Q'(DEPTH);
  localparam logic [3:0] CMD_RESET = 4'd8;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_Q-1:0]  count_reg;
  logic [CNT_W-1:0]  enq_cnt_reg;
  logic [CNT_W-1:0]  coal_cnt_reg;
  logic [CNT_W-1:0]  drop_cnt_reg;

  logic             clear;
  logic             is_full;
  logic             is_empty;
  logic [PTR_W-1:0] tail_ptr;
  logic             deq;
  logic             coal;
  logic             enq;
  logic             drop;

  // All classification uses pre-edge state; the trace RESET command acts like rst.
  assign clear    = rst || (n == CMD_RESET);
  assign is_full  = (count_reg == DEPTH_Q);
  assign is_empty = (count_reg == '0);
  assign tail_ptr = wr_ptr_reg - PTR_W'(1);
  assign deq      = !is_empty && l2_ready;
  assign coal     = req_valid && !is_empty && (req_addr == mem[tail_ptr]);
  assign enq      = req_valid && !coal && (!is_full || deq);
  assign drop     = req_valid && !coal && is_full && !deq;

  always_ff @(posedge clk) begin
    if (!clear && enq) begin
      mem[wr_ptr_reg] <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      enq_cnt_reg  <= '0;
      coal_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (enq && !deq) begin
        count_reg <= count_reg + CNT_Q'(1);
      end else if (deq && !enq) begin
        count_reg <= count_reg - CNT_Q'(1);
      end
      // Statistics saturate rather than wrap.
      if (enq && (enq_cnt_reg != '1)) begin
        enq_cnt_reg <= enq_cnt_reg + CNT_W'(1);
      end
      if (coal && (coal_cnt_reg != '1)) begin
        coal_cnt_reg <= coal_cnt_reg + CNT_W'(1);
      end
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign l2_valid = !is_empty;
  assign l2_addr  = mem[rd_ptr_reg];
  assign full     = is_full;
  assign empty    = is_empty;
  assign count    = count_reg;
  assign enq_cnt  = enq_cnt_reg;
  assign coal_cnt = coal_cnt_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_l2_req_queue.sv
// Directed self-checking bench for l2_req_queue; a second narrow-counter
// instance shares the stimulus and is used for the saturation case.
module tb_l2_req_queue;

  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        n;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              l2_ready;

  logic              l2_valid, full, empty;
  logic [ADDR_W-1:0] l2_addr;
  logic [3:0]        count;
  logic [31:0]       enq_cnt, coal_cnt, drop_cnt;

  logic              s_l2_valid, s_full, s_empty;
  logic [ADDR_W-1:0] s_l2_addr;
  logic [3:0]        s_count;
  logic [3:0]        s_enq_cnt, s_coal_cnt, s_drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l2_req_queue #(.DEPTH(8), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .n(n), .req_valid(req_valid), .req_addr(req_addr),
    .l2_valid(l2_valid), .l2_addr(l2_addr), .l2_ready(l2_ready),
    .full(full), .empty(empty), .count(count),
    .enq_cnt(enq_cnt), .coal_cnt(coal_cnt), .drop_cnt(drop_cnt)
  );

  l2_req_queue #(.DEPTH(8), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .n(n), .req_valid(req_valid), .req_addr(req_addr),
    .l2_valid(s_l2_valid), .l2_addr(s_l2_addr), .l2_ready(l2_ready),
    .full(s_full), .empty(s_empty), .count(s_count),
    .enq_cnt(s_enq_cnt), .coal_cnt(s_coal_cnt), .drop_cnt(s_drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    l2_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] wrap_seq(input int h);
    if (h < 7) return ADDR_W'(32'h11 + h);
    return ADDR_W'(32'h20 + (h - 7));
  endfunction

  initial begin
    rst = 1'b1; n = 4'd0; req_valid = 1'b0; req_addr = '0; l2_ready = 1'b0;
    #1;
    step();
    check("rst_l2_valid", l2_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_enq_cnt", enq_cnt, 0);
    rst = 1'b0;

    // Single enqueue is visible right after the edge.
    send(26'h0000100);
    check("t1_l2_valid", l2_valid, 1);
    check("t1_l2_addr", l2_addr, 26'h0000100);
    check("t1_count", count, 1);
    check("t1_enq_cnt", enq_cnt, 1);

    // Back-to-back duplicates coalesce; non-adjacent ones do not.
    do_reset();
    for (int i = 0; i < 3; i++) send(26'h0000100);
    check("t2_count", count, 1);
    check("t2_enq_cnt", enq_cnt, 1);
    check("t2_coal_cnt", coal_cnt, 2);
    send(26'h0000101);
    send(26'h0000100);
    check("t2_count_nonadj", count, 3);
    check("t2_coal_nonadj", coal_cnt, 2);

    // Overflow drops, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) send(ADDR_W'(32'h10 + i));
    check("t3_full", full, 1);
    check("t3_count", count, 8);
    check("t3_enq_cnt", enq_cnt, 8);
    check("t3_drop_cnt", drop_cnt, 2);
    l2_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_head%0d_valid", i), l2_valid, 1);
      check($sformatf("t3_head%0d_addr", i), l2_addr, ADDR_W'(32'h10 + i));
      step();
    end
    l2_ready = 1'b0;
    check("t3_empty", empty, 1);
    check("t3_l2_valid", l2_valid, 0);

    // Full queue with simultaneous pop and push, then wrap with continuous traffic.
    do_reset();
    for (int i = 0; i < 8; i++) send(ADDR_W'(32'h10 + i));
    check("t4_full_before", full, 1);
    check("t4_head_before", l2_addr, 26'h10);
    l2_ready = 1'b1;
    send(26'h20);
    check("t4_count", count, 8);
    check("t4_drop_cnt", drop_cnt, 0);
    check("t4_enq_cnt", enq_cnt, 9);
    for (int h = 0; h < 20; h++) begin
      check($sformatf("t4_wrap_head%0d", h), l2_addr, wrap_seq(h));
      send(ADDR_W'(32'h21 + h));
    end
    l2_ready = 1'b0;
    check("t4_wrap_count", count, 8);
    check("t4_wrap_drop", drop_cnt, 0);
    check("t4_wrap_head", l2_addr, wrap_seq(20));

    // Coalescing against a tail entry that is popped in the same cycle.
    do_reset();
    send(26'h60);
    l2_ready = 1'b1;
    send(26'h60);
    l2_ready = 1'b0;
    check("cdq_coal_cnt", coal_cnt, 1);
    check("cdq_empty", empty, 1);
    check("cdq_enq_cnt", enq_cnt, 1);

    // Trace RESET command and rst both clear everything and ignore a concurrent request.
    do_reset();
    for (int i = 0; i < 5; i++) send(ADDR_W'(32'h40 + i));
    check("t5_count_pre", count, 5);
    check("t5_enq_pre", enq_cnt, 5);
    n = 4'd9;
    step();
    n = 4'd0;
    check("t5_print_count", count, 5);
    check("t5_print_head", l2_addr, 26'h40);
    n = 4'd8;
    l2_ready = 1'b1;
    send(26'h50);
    n = 4'd0;
    l2_ready = 1'b0;
    check("t5_cmd_empty", empty, 1);
    check("t5_cmd_count", count, 0);
    check("t5_cmd_enq", enq_cnt, 0);
    check("t5_cmd_coal", coal_cnt, 0);
    check("t5_cmd_drop", drop_cnt, 0);
    for (int i = 0; i < 5; i++) send(ADDR_W'(32'h40 + i));
    rst = 1'b1;
    send(26'h50);
    rst = 1'b0;
    check("t5_rst_empty", empty, 1);
    check("t5_rst_count", count, 0);
    check("t5_rst_enq", enq_cnt, 0);
    check("t5_rst_valid", l2_valid, 0);

    // Saturation: narrow instance holds at all-ones, wide one keeps counting.
    do_reset();
    for (int i = 0; i < 16; i++) send(26'h5);
    check("t6_sat_coal_15", s_coal_cnt, 4'hF);
    check("t6_wide_coal_15", coal_cnt, 15);
    send(26'h5);
    check("t6_sat_coal_hold", s_coal_cnt, 4'hF);
    check("t6_wide_coal_16", coal_cnt, 16);
    check("t6_sat_enq", s_enq_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
